// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the integer register file: shares WE3/A3/WD3 between core
// writeback and the debug port, and runs an INIT_VALUE clear sweep after reset or on request.
module regfile_write_arbiter #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    parameter bit                CLEAR_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_gnt,
    input  logic              clr_req,
    output logic              init_done,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3
);

    localparam int                NREG      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

    typedef enum logic { CLEAR, RUN } state_t;
    typedef enum logic { SRC_CORE, SRC_DBG } src_t;

    state_t            state, state_nxt;
    src_t              rr_last, rr_last_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;

    logic              both, core_win, dbg_win;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // On a tie the requester that did not win the previous tie goes first.
    always_comb begin
        both     = wb_we & dbg_req;
        dbg_win  = dbg_req & (~wb_we | (rr_last == SRC_CORE));
        core_win = wb_we & ~dbg_win;
        win_addr = dbg_win ? dbg_addr : wb_addr;
        win_data = dbg_win ? dbg_data : wb_data;
    end

    always_comb begin
        WE3        = 1'b0;
        A3         = '0;
        WD3        = '0;
        dbg_gnt    = 1'b0;
        core_stall = 1'b1;
        init_done  = 1'b0;
        if (rst) begin
            case (state)
                CLEAR: begin
                    WE3 = 1'b1;
                    A3  = clr_cnt;
                    WD3 = INIT_VALUE;
                end
                RUN: begin
                    init_done  = 1'b1;
                    dbg_gnt    = dbg_win;
                    core_stall = wb_we & ~core_win;
                    // x0 is hardwired zero: grant the request but suppress the write.
                    if ((core_win | dbg_win) && win_addr != '0) begin
                        WE3 = 1'b1;
                        A3  = win_addr;
                        WD3 = win_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        rr_last_nxt = rr_last;
        case (state)
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt   = RUN;
                    clr_cnt_nxt = '0;
                end
            end
            RUN: begin
                if (both)
                    rr_last_nxt = dbg_win ? SRC_DBG : SRC_CORE;
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR_EN ? CLEAR : RUN;
            clr_cnt <= '0;
            rr_last <= SRC_DBG;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            rr_last <= rr_last_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, hand sequences and random traffic
// checked against a cycle-level reference model and a shadow register file.
module tb_regfile_write_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wb_we = 1'b0, dbg_req = 1'b0, clr_req = 1'b0;
    logic [AW-1:0] wb_addr = '0, dbg_addr = '0;
    logic [DW-1:0] wb_data = '0, dbg_data = '0;
    logic          core_stall, dbg_gnt, init_done, WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .INIT_VALUE('0), .CLEAR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_gnt(dbg_gnt),
        .clr_req(clr_req), .init_done(init_done),
        .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    // Shadow register file fed only by the DUT's write port.
    logic [DW-1:0] rf [NREG];
    always @(posedge clk) if (WE3) rf[A3] <= WD3;

    typedef struct {
        logic          r, we, dr, cr;
        logic [AW-1:0] wa, da;
        logic [DW-1:0] wd, dd;
    } stim_t;

    typedef struct {
        stim_t         s;
        logic          x_we, x_gnt, x_stall;
        logic [AW-1:0] x_a;
        logic [DW-1:0] x_wd;
    } vec_t;

    int passed = 0;
    int total  = 0;

    // Reference model: sweep position, who won the last tie, expected register contents.
    bit            m_clr;
    int            m_idx;
    bit            m_last_dbg;
    logic [DW-1:0] mrf [NREG];
    logic          e_we, e_gnt, e_stall, e_done;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd;

    function automatic stim_t mk(logic we, logic [AW-1:0] wa, logic [DW-1:0] wd,
                                 logic dr, logic [AW-1:0] da, logic [DW-1:0] dd);
        stim_t s;
        s.r = 1'b1; s.cr = 1'b0;
        s.we = we; s.wa = wa; s.wd = wd;
        s.dr = dr; s.da = da; s.dd = dd;
        return s;
    endfunction

    function automatic void model_eval();
        bit dbg_first;
        int addr;
        e_we = 0; e_a = '0; e_wd = '0; e_gnt = 0; e_stall = 1; e_done = 0;
        if (!rst) return;
        if (m_clr) begin
            e_we = 1; e_a = AW'(m_idx); e_wd = '0;
            return;
        end
        e_done    = 1;
        dbg_first = (wb_we && dbg_req) ? !m_last_dbg : dbg_req;
        e_gnt     = dbg_req && dbg_first;
        e_stall   = wb_we && dbg_first;
        if (wb_we || dbg_req) begin
            addr = dbg_first ? int'(dbg_addr) : int'(wb_addr);
            if (addr != 0) begin
                e_we = 1;
                e_a  = AW'(addr);
                e_wd = dbg_first ? dbg_data : wb_data;
            end
        end
    endfunction

    function automatic void model_commit();
        if (!rst) begin
            m_clr = 1; m_idx = 0; m_last_dbg = 1;
            return;
        end
        if (e_we) mrf[e_a] = e_wd;
        if (m_clr) begin
            m_idx++;
            if (m_idx == NREG) begin m_clr = 0; m_idx = 0; end
        end else begin
            if (wb_we && dbg_req) m_last_dbg = e_gnt;
            if (clr_req) begin m_clr = 1; m_idx = 0; end
        end
    endfunction

    task automatic check_out(input string nm);
        total++;
        if (WE3 === e_we && A3 === e_a && WD3 === e_wd && dbg_gnt === e_gnt &&
            core_stall === e_stall && init_done === e_done)
            passed++;
        else
            $display("FAIL %s t=%0t got we=%b a=%0d wd=%h gnt=%b stall=%b done=%b want we=%b a=%0d wd=%h gnt=%b stall=%b done=%b",
                     nm, $time, WE3, A3, WD3, dbg_gnt, core_stall, init_done,
                     e_we, e_a, e_wd, e_gnt, e_stall, e_done);
    endtask

    task automatic apply(input stim_t s);
        rst = s.r; wb_we = s.we; wb_addr = s.wa; wb_data = s.wd;
        dbg_req = s.dr; dbg_addr = s.da; dbg_data = s.dd; clr_req = s.cr;
    endtask

    task automatic cyc(input stim_t s, input string nm);
        @(posedge clk);
        #1 apply(s);
        #3 model_eval();
        check_out(nm);
        model_commit();
    endtask

    function automatic stim_t rnd_stim();
        stim_t s;
        s.r  = 1'b1;
        s.we = $urandom_range(0, 1) == 1;
        s.wa = AW'($urandom_range(0, NREG - 1));
        s.wd = DW'($urandom);
        s.dr = $urandom_range(0, 2) == 0;
        s.da = AW'($urandom_range(0, NREG - 1));
        s.dd = DW'($urandom);
        s.cr = $urandom_range(0, 39) == 0;
        return s;
    endfunction

    vec_t  tbl [11];
    stim_t idle, s;

    initial begin
        m_clr = 1; m_idx = 0; m_last_dbg = 1;
        idle = mk(0, 0, 0, 0, 0, 0);

        // Vectors assume entry from RUN right after a sweep (last tie owner = debug).
        tbl[0]  = '{mk(1, 5, 32'h36, 0, 0, 0),            1, 0, 0, 5, 32'h36};
        tbl[1]  = '{mk(1, 3, 32'h11, 1, 7, 32'h22),       1, 0, 0, 3, 32'h11};
        tbl[2]  = '{mk(1, 3, 32'h11, 1, 7, 32'h22),       1, 1, 1, 7, 32'h22};
        tbl[3]  = '{mk(1, 3, 32'h11, 1, 7, 32'h22),       1, 0, 0, 3, 32'h11};
        tbl[4]  = '{mk(1, 3, 32'h11, 1, 7, 32'h22),       1, 1, 1, 7, 32'h22};
        tbl[5]  = '{mk(0, 0, 0, 1, 0, 32'hFFFF_FFFF),     0, 1, 0, 0, 32'h0};
        tbl[6]  = '{mk(0, 0, 0, 0, 0, 0),                 0, 0, 0, 0, 32'h0};
        tbl[7]  = '{mk(1, 0, 32'h55, 0, 0, 0),            0, 0, 0, 0, 32'h0};
        tbl[8]  = '{mk(0, 0, 0, 1, 31, 32'hDEAD_BEEF),    1, 1, 0, 31, 32'hDEAD_BEEF};
        tbl[9]  = '{mk(1, 0, 32'h1, 1, 4, 32'h2),         0, 0, 0, 0, 32'h0};
        tbl[10] = '{mk(1, 0, 32'h1, 1, 4, 32'h2),         1, 1, 1, 4, 32'h2};

        // Reset held with a core request pending.
        s = mk(1, 5, 32'h99, 1, 6, 32'h77);
        s.r = 1'b0;
        for (int i = 0; i < 3; i++) cyc(s, "reset_hold");

        // Release into the sweep; requests must be ignored for all 32 cycles.
        for (int i = 0; i < NREG; i++) cyc(mk(1, 5, 32'h99, 1, 6, 32'h77), "sweep_after_reset");

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].s, "table_model");
            total++;
            if (WE3 === tbl[i].x_we && dbg_gnt === tbl[i].x_gnt && core_stall === tbl[i].x_stall &&
                A3 === tbl[i].x_a && WD3 === tbl[i].x_wd && init_done === 1'b1)
                passed++;
            else
                $display("FAIL table[%0d] got we=%b gnt=%b stall=%b a=%0d wd=%h done=%b want we=%b gnt=%b stall=%b a=%0d wd=%h done=1",
                         i, WE3, dbg_gnt, core_stall, A3, WD3, init_done,
                         tbl[i].x_we, tbl[i].x_gnt, tbl[i].x_stall, tbl[i].x_a, tbl[i].x_wd);
        end

        // clr_req alongside a core write to x9: write lands, then a full sweep.
        s = mk(1, 9, 32'h20, 0, 0, 0);
        s.cr = 1'b1;
        cyc(s, "clr_with_write");
        cyc(idle, "clr_sweep");
        total++;
        if (rf[9] === 32'h20) passed++;
        else $display("FAIL x9_written got %h want 00000020", rf[9]);
        for (int i = 1; i < NREG; i++) cyc(idle, "clr_sweep");
        cyc(idle, "clr_back_to_run");

        for (int i = 0; i < 300; i++) cyc(rnd_stim(), "random");

        for (int i = 0; i < 40 && m_clr; i++) cyc(idle, "drain_sweep");

        // Reset asserted on sweep cycle 10 drops the outputs asynchronously.
        s = idle;
        s.cr = 1'b1;
        cyc(s, "clr_for_rst");
        for (int i = 0; i < 10; i++) cyc(idle, "sweep_pre_rst");
        @(posedge clk);
        #1 apply(idle);
        #3 model_eval();
        check_out("sweep_a10");
        rst = 1'b0;
        #1 model_eval();
        check_out("rst_async");
        model_commit();
        s = idle;
        s.r = 1'b0;
        cyc(s, "rst_mid_sweep");
        for (int i = 0; i < NREG; i++) cyc(idle, "sweep_restart");

        for (int i = 0; i < 80; i++) begin
            s = rnd_stim();
            s.cr = 1'b0;
            cyc(s, "random_tail");
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < NREG; i++) begin
            total++;
            if (rf[i] === mrf[i]) passed++;
            else $display("FAIL regfile[%0d] got %h want %h", i, rf[i], mrf[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (WE3/A3/WD3) of the 32-entry integer register file.
- Shares that port between two requesters: the core writeback path and a debug/loader port.
- After reset, and on request, runs a hardware sweep that writes INIT_VALUE to every register before normal operation.
- Sits between the writeback mux/debug unit and the register file. It stalls the core whenever the core's write is not accepted.

Parameters:
DATA_W, 32, width of the write data.
ADDR_W, 5, register address width; NREG = 2**ADDR_W.
INIT_VALUE, 0, value written to each register during a clear sweep.
CLEAR_EN, 1, 1 = sweep after reset release; 0 = enter RUN directly after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
wb_we  in  1  core writeback request.
wb_addr  in  ADDR_W  core destination register.
wb_data  in  DATA_W  core writeback data.
core_stall  out  1  1 = core write not accepted this cycle; core must hold its PC and request.
dbg_req  in  1  debug write request; must be held until granted.
dbg_addr  in  ADDR_W  debug destination register.
dbg_data  in  DATA_W  debug write data.
dbg_gnt  out  1  1 = debug write accepted this cycle.
clr_req  in  1  single-cycle pulse; starts a clear sweep from RUN.
init_done  out  1  1 = in RUN, register file contents are valid.
WE3  out  1  register file write enable.
A3  out  ADDR_W  register file write address.
WD3  out  DATA_W  register file write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=CLEAR if CLEAR_EN=1, else RUN; clr_cnt=0; rr_last=DBG.
  - Outputs are forced regardless of state: WE3=0, A3=0, WD3=0, dbg_gnt=0, core_stall=1, init_done=0.
- State CLEAR:
  - Each cycle: WE3=1, A3=clr_cnt, WD3=INIT_VALUE; x0 is included.
  - clr_cnt increments every cycle.
  - After the write to address NREG-1, go to RUN and set clr_cnt=0. A sweep takes exactly NREG cycles.
  - Throughout CLEAR: core_stall=1, dbg_gnt=0, init_done=0. Requests are ignored, not queued.
  - clr_req has no effect while already in CLEAR.
- State RUN:
  - init_done=1.
  - Grant is combinational in the same cycle as the request; the write lands on that rising edge.
  - Neither requester: WE3=0, dbg_gnt=0, core_stall=0.
  - One requester: that requester is granted.
  - Both requesters: round-robin. The winner is the requester other than rr_last.
  - rr_last updates only on a cycle where both requested, and takes the winner's value.
  - Winner drives A3/WD3.
  - The loser sees core_stall=1 (core) or dbg_gnt=0 (debug).
  - core_stall=1 only when wb_we=1 and the core is not granted.
  - x0 protection: a granted write to address 0 still asserts the grant (dbg_gnt=1 or core_stall=0) but forces WE3=0.
  - clr_req=1 in RUN:
    - The current-cycle arbitration completes normally.
    - Next state is CLEAR with clr_cnt=0.
    - init_done deasserts on the next cycle.
- When WE3=0, A3 and WD3 are driven to 0, so idle outputs are deterministic.
- Reset asserted mid-sweep or mid-grant: outputs drop immediately to their reset values. The sweep restarts from 0 after release.
- Combinational paths from inputs to outputs exist only for the RUN-state grant. There are no other combinational loops.

Test Plan:
- CLEAR_EN=1, release reset: WE3=1 for exactly 32 cycles with A3=0..31 and WD3=0, then init_done=1. core_stall=1 for all 32 cycles even with wb_we=1.
- RUN, wb_we=1, wb_addr=5, wb_data=0x36, dbg_req=0: WE3=1, A3=5, WD3=0x36, core_stall=0 in the same cycle.
- RUN, both requesting for 4 consecutive cycles: grants go core, dbg, core, dbg. core_stall=1 on cycles 2 and 4; dbg_gnt=1 on cycles 2 and 4.
- RUN, dbg_req=1, dbg_addr=0, dbg_data=0xFFFFFFFF: dbg_gnt=1 and WE3=0.
- RUN, clr_req pulse with a simultaneous core write to x9=0x20: x9 is written with 0x20. init_done=0 from the next cycle. A 32-cycle sweep follows, then init_done=1.
- rst driven low at sweep cycle 10: WE3=0 immediately. After release, the sweep restarts with A3=0.
